// File: rtl/ctz_index_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ctz_index_decoder_if
// Description : Index-stream input and merged-mask output handshake bundle
//               for ctz_index_decoder. master = producer/consumer side,
//               slave = the decoder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctz_index_decoder_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [IW-1:0]    in_count;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mask;
    logic [3:0]       out_beats;
    logic             out_err;
    logic             out_dup;

    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_beats, out_err, out_dup
    );

    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_beats, out_err, out_dup
    );
endinterface
`default_nettype wire

// File: rtl/ctz_index_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ctz_index_decoder
// Description : Decodes a stream of CTZ-encoded bit indices to one-hot masks,
//               OR-merges them until a beat marked last, and queues each
//               merged group in a small output FIFO.
//               Optional feature macro: CTZ_INDEX_DECODER_DUP_CHECK_EN
//               (enables duplicate-bit detection; out_dup is 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module ctz_index_decoder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ctz_index_decoder_if.slave    bus
);
    localparam int IW = $clog2(WIDTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = 4;
    localparam logic [BW-1:0] C_BEATS_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    // Accumulator
    logic [WIDTH-1:0] acc_mask_q,  acc_mask_d;
    logic [BW-1:0]    acc_beats_q, acc_beats_d;
    logic             acc_err_q,   acc_err_d;

    // Decode and merged group value
    logic [WIDTH-1:0] w_dec;
    logic             w_illegal;
    logic [WIDTH-1:0] w_grp_mask;
    logic [BW-1:0]    w_grp_beats;
    logic             w_grp_err;

    // FIFO
    logic [WIDTH-1:0] mem_mask_q  [DEPTH];
    logic [BW-1:0]    mem_beats_q [DEPTH];
    logic             mem_err_q   [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW-1:0]    w_occ;
    state_t           state_q, state_d;

    logic w_full, w_empty;
    logic w_accept, w_push, w_pop;

    // Index decode: in-range -> one-hot, WIDTH -> empty, above WIDTH -> illegal
    always_comb begin
        w_dec     = '0;
        w_illegal = (bus.in_count > IW'(WIDTH));
        for (int k = 0; k < WIDTH; k++) begin
            w_dec[k] = (bus.in_count == IW'(k));
        end
    end

    // Group value as it would stand after merging the current beat
    always_comb begin
        w_grp_mask  = acc_mask_q | w_dec;
        w_grp_beats = (acc_beats_q == C_BEATS_MAX) ? acc_beats_q : acc_beats_q + 1'b1;
        w_grp_err   = acc_err_q | w_illegal;
    end

    // Flags from occupancy state; a pop frees the slot for a same-cycle push
    assign w_full       = (state_q == ST_FULL);
    assign w_empty      = (state_q == ST_EMPTY);
    assign bus.in_ready = ~w_full | bus.out_ready;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_push       = w_accept & bus.in_last;
    assign w_pop        = ~w_empty & bus.out_ready;
    assign w_occ        = wr_q - rd_q;

    // Accumulator next state: merge on non-last beat, clear when group closes
    always_comb begin
        acc_mask_d  = acc_mask_q;
        acc_beats_d = acc_beats_q;
        acc_err_d   = acc_err_q;
        if (w_accept) begin
            if (bus.in_last) begin
                acc_mask_d  = '0;
                acc_beats_d = '0;
                acc_err_d   = 1'b0;
            end else begin
                acc_mask_d  = w_grp_mask;
                acc_beats_d = w_grp_beats;
                acc_err_d   = w_grp_err;
            end
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_mask_q  <= '0;
            acc_beats_q <= '0;
            acc_err_q   <= 1'b0;
        end else begin
            acc_mask_q  <= acc_mask_d;
            acc_beats_q <= acc_beats_d;
            acc_err_q   <= acc_err_d;
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_mask_q[wr_q[AW-1:0]]  <= w_grp_mask;
            mem_beats_q[wr_q[AW-1:0]] <= w_grp_beats;
            mem_err_q[wr_q[AW-1:0]]   <= w_grp_err;
        end
    end

    // FIFO pointers, wrapping modulo 2*DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (w_push) wr_q <= wr_q + 1'b1;
            if (w_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Occupancy next state: +1 on push-only, -1 on pop-only
    always_comb begin
        state_d = state_q;
        case ({w_push, w_pop})
            2'b10:   state_d = (w_occ == PW'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL;
            2'b01:   state_d = (w_occ == PW'(1)) ? ST_EMPTY : ST_PARTIAL;
            default: state_d = state_q;
        endcase
    end

    // Head of FIFO, forced to zero while empty
    assign bus.out_valid = ~w_empty;
    assign bus.out_mask  = w_empty ? '0   : mem_mask_q[rd_q[AW-1:0]];
    assign bus.out_beats = w_empty ? '0   : mem_beats_q[rd_q[AW-1:0]];
    assign bus.out_err   = w_empty ? 1'b0 : mem_err_q[rd_q[AW-1:0]];

`ifdef CTZ_INDEX_DECODER_DUP_CHECK_EN
    logic acc_dup_q, acc_dup_d;
    logic w_grp_dup;
    logic mem_dup_q [DEPTH];

    // Duplicate detection: beat hits a bit already present in the group
    always_comb begin
        w_grp_dup = acc_dup_q | (|(acc_mask_q & w_dec));
        acc_dup_d = acc_dup_q;
        if (w_accept) acc_dup_d = bus.in_last ? 1'b0 : w_grp_dup;
    end

    // Duplicate flag accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_dup_q <= 1'b0;
        else        acc_dup_q <= acc_dup_d;
    end

    // Per-entry duplicate flag storage
    always_ff @(posedge clk) begin
        if (w_push) mem_dup_q[wr_q[AW-1:0]] <= w_grp_dup;
    end

    assign bus.out_dup = w_empty ? 1'b0 : mem_dup_q[rd_q[AW-1:0]];
`else
    assign bus.out_dup = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctz_index_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctz_index_decoder
// Description : Self-checking bench for ctz_index_decoder: directed scenarios
//               plus randomized index streams against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctz_index_decoder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
`ifdef CTZ_INDEX_DECODER_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] mask;
        int         beats;
        bit         err;
        bit         dup;
    } grp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctz_index_decoder_if #(.WIDTH(WIDTH)) bus ();

    ctz_index_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: open group plus a queue of closed groups
    grp_t       q[$];
    logic [7:0] m_mask;
    int         m_beats;
    bit         m_err;
    bit         m_dup;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_mask = 8'h00; m_beats = 0; m_err = 0; m_dup = 0;
    endtask

    task automatic check_outputs(input bit ordy);
        check("in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) || ordy));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_mask", 32'(bus.out_mask), 32'(q[0].mask));
            check("out_beats", 32'(bus.out_beats), 32'(q[0].beats));
            check("out_err", 32'(bus.out_err), 32'(q[0].err));
            check("out_dup", 32'(bus.out_dup), 32'(q[0].dup & DUP_EN));
        end else begin
            check("out_mask_idle", 32'(bus.out_mask), 32'h0);
            check("out_beats_idle", 32'(bus.out_beats), 32'h0);
            check("out_err_idle", 32'(bus.out_err), 32'h0);
            check("out_dup_idle", 32'(bus.out_dup), 32'h0);
        end
    endtask

    // One clock: drive, check at negedge, then advance the model past posedge
    task automatic cycle(input bit v, input int cnt, input bit last, input bit ordy);
        bit         fire;
        bit         pop;
        logic [7:0] d;
        bit         ill;
        bus.in_valid  = v;
        bus.in_count  = 4'(cnt);
        bus.in_last   = last;
        bus.out_ready = ordy;
        @(negedge clk);
        check_outputs(ordy);
        fire = v && ((q.size() < DEPTH) || ordy);
        pop  = (q.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (fire) begin
            d   = (cnt < 8) ? 8'(1 << cnt) : 8'h00;
            ill = (cnt > 8);
            m_dup   = m_dup | ((m_mask & d) != 8'h00);
            m_mask  = m_mask | d;
            m_beats = (m_beats + 1 > 15) ? 15 : m_beats + 1;
            m_err   = m_err | ill;
            if (last) begin
                q.push_back('{mask: m_mask, beats: m_beats, err: m_err, dup: m_dup});
                m_mask = 8'h00; m_beats = 0; m_err = 0; m_dup = 0;
            end
        end
    endtask

    initial begin
        model_clear();
        bus.in_valid  = 1'b0;
        bus.in_count  = 4'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check_outputs(1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0);

        // Beats 3, 0, 7(last)
        cycle(1, 3, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 7, 1, 1);
        check("grp1_mask", 32'(bus.out_mask), 32'h89);
        check("grp1_beats", 32'(bus.out_beats), 32'd3);
        check("grp1_err", 32'(bus.out_err), 32'd0);
        check("grp1_dup", 32'(bus.out_dup), 32'd0);
        cycle(0, 0, 0, 1);
        check("grp1_drained", 32'(bus.out_valid), 32'd0);

        // Empty index then illegal index
        cycle(1, 8, 1, 0);
        cycle(1, 12, 1, 0);
        check("empty_mask", 32'(bus.out_mask), 32'h00);
        check("empty_beats", 32'(bus.out_beats), 32'd1);
        check("empty_err", 32'(bus.out_err), 32'd0);
        cycle(0, 0, 0, 1);
        check("illegal_mask", 32'(bus.out_mask), 32'h00);
        check("illegal_err", 32'(bus.out_err), 32'd1);
        cycle(0, 0, 0, 1);

        // Duplicate bit 5
        cycle(1, 5, 0, 1);
        cycle(1, 5, 1, 1);
        check("dup_mask", 32'(bus.out_mask), 32'h20);
        check("dup_beats", 32'(bus.out_beats), 32'd2);
        check("dup_flag", 32'(bus.out_dup), 32'(DUP_EN));
        cycle(0, 0, 0, 1);

        // Backpressure: fill, stall, then coincident push+pop while full
        cycle(1, 1, 1, 0);
        cycle(1, 2, 1, 0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1, 4, 1, 0);
        check("stall_head", 32'(bus.out_mask), 32'h02);
        cycle(1, 4, 1, 1);
        check("pop2_head", 32'(bus.out_mask), 32'h04);
        cycle(0, 0, 0, 1);
        check("pop3_head", 32'(bus.out_mask), 32'h10);
        cycle(0, 0, 0, 1);
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Beat count saturation
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 1);
        cycle(1, 1, 1, 1);
        check("sat_beats", 32'(bus.out_beats), 32'd15);
        check("sat_mask", 32'(bus.out_mask), 32'h03);
        cycle(0, 0, 0, 1);

        // Asynchronous reset mid-group with one entry queued
        cycle(1, 0, 1, 0);
        cycle(1, 6, 0, 0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs(1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 1, 1, 1);
        check("rst_recover_mask", 32'(bus.out_mask), 32'h02);
        check("rst_recover_beats", 32'(bus.out_beats), 32'd1);
        cycle(0, 0, 0, 1);

        // Randomized streams
        for (int i = 0; i < 3000; i++) begin
            int c;
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            cycle($urandom_range(0, 3) != 0, c, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
